mem_controller: RTL and testbench

- Sits directly downstream of the CPU datapath. Consumes its Address/WriteData and the control unit's memory strobes, and returns ReadData.
- Routes each access either to an external byte-wide bus with a req/ack handshake (multi-cycle, stalls the CPU) or to local memory-mapped I/O registers (single cycle).
- Provides Stall so the control unit freezes PC/register writes while an external access is outstanding.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_io_regs.sv | 75 +++++++
 rtl/mem_controller.sv | 153 +++++++++++++++
 tb/tb_mem_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and the I/O register map for mem_controller.
//   mc_state_t    : external-access FSM states (IDLE -> WAIT -> DONE -> IDLE)
//   ADDR_*        : addresses of the local memory-mapped I/O registers
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam logic [7:0] ADDR_GPIO_OUT = 8'hFC;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'hFD;
    localparam logic [7:0] ADDR_STATUS   = 8'hFE;
    localparam logic [7:0] ADDR_RSVD     = 8'hFF;

endpackage

// File: rtl/mem_io_regs.sv
// mem_io_regs: local memory-mapped I/O registers of mem_controller.
//   GPIO_OUT (0xFC, RW), GPIO_IN (0xFD, RO through a 2-flop synchronizer),
//   STATUS (0xFE, bit0 = sticky bus error, write 1 to clear), 0xFF reserved.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   addr       : register address (only meaningful when the access is I/O)
//   wdata      : store data
//   wr_en      : I/O write strobe, qualified by the controller (IDLE, I/O range)
//   err_set    : one-cycle pulse that sets the sticky bus error
//   gpio_in    : asynchronous input pins
//   gpio_out   : GPIO output register
//   rdata      : combinational read mux output
module mem_io_regs
    import mem_ctrl_pkg::*;
#(
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        addr,
    input  logic [7:0]        wdata,
    input  logic              wr_en,
    input  logic              err_set,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        rdata
);

    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic              bus_error;

    // gpio_in is asynchronous; only the second flop is ever read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (wr_en && addr == ADDR_GPIO_OUT) begin
            gpio_out <= GPIO_W'(wdata);
        end
    end

    // Set and clear never coincide: errors are raised in WAIT, I/O writes
    // only happen in IDLE. Set still takes priority to keep it sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_error <= 1'b0;
        end else if (err_set) begin
            bus_error <= 1'b1;
        end else if (wr_en && addr == ADDR_STATUS && wdata[0]) begin
            bus_error <= 1'b0;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_GPIO_OUT: rdata = 8'(gpio_out);
            ADDR_GPIO_IN:  rdata = 8'(gpio_sync2);
            ADDR_STATUS:   rdata = {7'b0, bus_error};
            ADDR_RSVD:     rdata = 8'h00;
            default:       rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/mem_controller.sv
// mem_controller: routes CPU loads/stores either to local memory-mapped I/O
// (single cycle) or to an external byte-wide req/ack bus (multi-cycle, with
// Stall asserted so the CPU freezes while the access is outstanding).
// Optional feature macro: MEMCTRL_TIMEOUT_EN -- when defined, an external
// access that sees no bus_ack within TIMEOUT_CYCLES WAIT cycles is aborted,
// returns 8'hFF and sets the sticky STATUS bus-error bit.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   Address/WriteData : CPU access address and store data
//   MemWrite_Enable   : store strobe (wins if both strobes are high)
//   MemRead_Enable    : load strobe
//   ReadData          : load data to the write-back mux
//   Stall             : CPU must hold its state this cycle
//   bus_req/bus_we/bus_addr/bus_wdata : registered external bus request
//   bus_rdata/bus_ack : external read data and one-cycle completion pulse
//   gpio_in/gpio_out  : GPIO pins
module mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [7:0] IO_BASE        = 8'hFC,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         GPIO_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        Address,
    input  logic [7:0]        WriteData,
    input  logic              MemWrite_Enable,
    input  logic              MemRead_Enable,
    output logic [7:0]        ReadData,
    output logic              Stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [7:0]        bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out
);

    mc_state_t  state;
    logic [7:0] rd_latch;
    logic [7:0] io_rdata;
    logic       req;
    logic       is_io;
    logic       ext_req;
    logic       io_wr;
    logic       io_rd;
    logic       err_set;

    assign req     = MemRead_Enable | MemWrite_Enable;
    assign is_io   = (Address >= IO_BASE);
    assign ext_req = (state == IDLE) && req && !is_io;
    assign io_wr   = (state == IDLE) && MemWrite_Enable && is_io;
    assign io_rd   = (state == IDLE) && MemRead_Enable && !MemWrite_Enable && is_io;

    // Stall is combinational so the CPU freezes in the very cycle the
    // external access is first seen; DONE releases it for the retire edge.
    assign Stall = ext_req || (state == WAIT);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;

    // Expiry on the last WAIT cycle loses to a simultaneous ack.
    assign err_set = (state == WAIT) && !bus_ack && (to_cnt == '0);
`else
    assign err_set = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            rd_latch  <= 8'h00;
`ifdef MEMCTRL_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ext_req) begin
                        bus_addr  <= Address;
                        bus_wdata <= WriteData;
                        bus_we    <= MemWrite_Enable;
                        bus_req   <= 1'b1;
                        // Cleared so a completed write returns 0 in DONE.
                        rd_latch  <= 8'h00;
`ifdef MEMCTRL_TIMEOUT_EN
                        to_cnt    <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rd_latch <= bus_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEMCTRL_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        bus_req  <= 1'b0;
                        rd_latch <= 8'hFF;
                        state    <= DONE;
                    end else begin
                        to_cnt <= to_cnt - CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    // The strobe still present here belongs to the retiring
                    // instruction; never re-issue it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ReadData = 8'h00;
        if (state == DONE) begin
            ReadData = rd_latch;
        end else if (io_rd) begin
            ReadData = io_rdata;
        end
    end

    mem_io_regs #(
        .GPIO_W(GPIO_W)
    ) u_io_regs (
        .clk     (clk),
        .reset   (reset),
        .addr    (Address),
        .wdata   (WriteData),
        .wr_en   (io_wr),
        .err_set (err_set),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .rdata   (io_rdata)
    );

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed self-checking bench for mem_controller.
// Inputs change 2 time units after each rising edge; outputs are sampled
// there or 1 unit after an input change, never on the edge itself.
module tb_mem_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Address;
    logic [7:0] WriteData;
    logic       MemWrite_Enable;
    logic       MemRead_Enable;
    logic [7:0] ReadData;
    logic       Stall;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_controller #(
        .IO_BASE       (8'hFC),
        .TIMEOUT_CYCLES(4),
        .GPIO_W        (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Address        (Address),
        .WriteData      (WriteData),
        .MemWrite_Enable(MemWrite_Enable),
        .MemRead_Enable (MemRead_Enable),
        .ReadData       (ReadData),
        .Stall          (Stall),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset           = 1'b1;
        Address         = 8'h00;
        WriteData       = 8'h00;
        MemWrite_Enable = 1'b0;
        MemRead_Enable  = 1'b0;
        bus_rdata       = 8'h00;
        bus_ack         = 1'b0;
        gpio_in         = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_bus_req", bus_req, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_gpio_out", gpio_out, 8'h00);
        chk("rst_rdata", ReadData, 8'h00);
        chk("rst_bus_addr", bus_addr, 8'h00);
        chk("rst_bus_we", bus_we, 0);
        reset = 1'b0;
        tick();

        // GPIO_OUT write: single cycle, no stall, no bus traffic
        Address = 8'hFC; WriteData = 8'h5A; MemWrite_Enable = 1'b1;
        #1;
        chk("gpio_wr_stall", Stall, 0);
        chk("gpio_wr_bus_req", bus_req, 0);
        chk("gpio_wr_before_edge", gpio_out, 8'h00);
        tick();
        MemWrite_Enable = 1'b0;
        chk("gpio_wr_out", gpio_out, 8'h5A);
        chk("gpio_wr_bus_req2", bus_req, 0);
        MemRead_Enable = 1'b1;
        #1;
        chk("gpio_rd_back", ReadData, 8'h5A);
        chk("gpio_rd_stall", Stall, 0);
        Address = 8'hFE;
        #1;
        chk("status_rd_clean", ReadData, 8'h00);
        Address = 8'hFF;
        #1;
        chk("rsvd_rd", ReadData, 8'h00);

        // Write to 0xFF is ignored
        MemRead_Enable = 1'b0; MemWrite_Enable = 1'b1; WriteData = 8'h33;
        tick();
        MemWrite_Enable = 1'b0;
        chk("rsvd_wr_gpio", gpio_out, 8'h5A);
        Address = 8'hFC; MemRead_Enable = 1'b1;
        #1;
        chk("rsvd_wr_gpio_rd", ReadData, 8'h5A);
        MemRead_Enable = 1'b0;

        // GPIO_IN synchronizer: visible two edges after the change
        Address = 8'hFD; MemRead_Enable = 1'b1; gpio_in = 8'hA5;
        #1;
        chk("gpio_in_0clk", ReadData, 8'h00);
        tick();
        chk("gpio_in_1clk", ReadData, 8'h00);
        tick();
        chk("gpio_in_2clk", ReadData, 8'hA5);
        MemRead_Enable = 1'b0;

        // External read 0x10, ack on the second bus_req cycle
        Address = 8'h10; MemRead_Enable = 1'b1;
        #1;
        chk("ext_rd_stall_c0", Stall, 1);
        chk("ext_rd_req_c0", bus_req, 0);
        tick();
        chk("ext_rd_req_c1", bus_req, 1);
        chk("ext_rd_addr", bus_addr, 8'h10);
        chk("ext_rd_we", bus_we, 0);
        chk("ext_rd_stall_c1", Stall, 1);
        tick();
        chk("ext_rd_req_c2", bus_req, 1);
        chk("ext_rd_stall_c2", Stall, 1);
        bus_ack = 1'b1; bus_rdata = 8'h3C;
        tick();
        bus_ack = 1'b0; bus_rdata = 8'h00;
        chk("ext_rd_done_stall", Stall, 0);
        chk("ext_rd_done_data", ReadData, 8'h3C);
        chk("ext_rd_done_req", bus_req, 0);
        tick();
        MemRead_Enable = 1'b0;
        #1;
        chk("ext_rd_no_reissue", bus_req, 0);
        chk("ext_rd_idle_stall", Stall, 0);

        // Both strobes: treated as a write; ack as bus_req rises
        Address = 8'h20; WriteData = 8'h77; MemWrite_Enable = 1'b1; MemRead_Enable = 1'b1;
        #1;
        chk("both_stall_c0", Stall, 1);
        tick();
        chk("both_we", bus_we, 1);
        chk("both_wdata", bus_wdata, 8'h77);
        chk("both_addr", bus_addr, 8'h20);
        chk("both_req", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 8'hEE;
        tick();
        bus_ack = 1'b0; bus_rdata = 8'h00;
        chk("both_done_rdata", ReadData, 8'h00);
        chk("both_done_stall", Stall, 0);
        chk("both_done_req", bus_req, 0);
        MemWrite_Enable = 1'b0; MemRead_Enable = 1'b0;
        tick();

        // Stray ack in IDLE is ignored
        bus_ack = 1'b1; bus_rdata = 8'h99;
        tick();
        bus_ack = 1'b0;
        chk("stray_ack_req", bus_req, 0);
        chk("stray_ack_stall", Stall, 0);
        chk("stray_ack_rdata", ReadData, 8'h00);

`ifdef MEMCTRL_TIMEOUT_EN
        // Timeout with no ack: 4 WAIT cycles then DONE with 0xFF
        Address = 8'h40; MemRead_Enable = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to_last_wait_stall", Stall, 1);
        tick();
        chk("to_done_stall", Stall, 0);
        chk("to_done_rdata", ReadData, 8'hFF);
        chk("to_done_req", bus_req, 0);
        tick();
        Address = 8'hFE;
        #1;
        chk("to_status_set", ReadData, 8'h01);
        MemRead_Enable = 1'b0; MemWrite_Enable = 1'b1; WriteData = 8'h01;
        tick();
        MemWrite_Enable = 1'b0; MemRead_Enable = 1'b1;
        #1;
        chk("to_status_clr", ReadData, 8'h00);
        MemRead_Enable = 1'b0;

        // Ack on the final timeout cycle wins
        Address = 8'h41; MemRead_Enable = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus_ack = 1'b1; bus_rdata = 8'h12;
        tick();
        bus_ack = 1'b0; bus_rdata = 8'h00;
        chk("to_late_ack_rdata", ReadData, 8'h12);
        chk("to_late_ack_stall", Stall, 0);
        tick();
        Address = 8'hFE;
        #1;
        chk("to_late_ack_status", ReadData, 8'h00);
        MemRead_Enable = 1'b0;
        tick();
`endif

        // Reset asserted mid-WAIT
        Address = 8'h30; MemRead_Enable = 1'b1;
        tick();
        chk("rstw_req_before", bus_req, 1);
        #1;
        reset = 1'b1; MemRead_Enable = 1'b0;
        #1;
        chk("rstw_req", bus_req, 0);
        chk("rstw_stall", Stall, 0);
        chk("rstw_gpio", gpio_out, 8'h00);
        tick();
        reset = 1'b0;
        bus_ack = 1'b1; bus_rdata = 8'h55;
        tick();
        bus_ack = 1'b0;
        chk("rstw_late_ack_req", bus_req, 0);
        chk("rstw_late_ack_stall", Stall, 0);
        chk("rstw_late_ack_rdata", ReadData, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
